// File: rtl/bg_pkg.sv
// Shared definitions for the background-mean collector: FSM encoding,
// pixel channel width and the 8-bit saturation helper.
package bg_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_WAIT = 5'b00010,
    ST_ACC  = 5'b00100,
    ST_DIV  = 5'b01000,
    ST_DONE = 5'b10000
  } state_t;

  localparam int PIX_W    = 8;
  localparam int SAT_IN_W = 64;

  function automatic logic [PIX_W-1:0] sat8(input logic [SAT_IN_W-1:0] v);
    if (v > SAT_IN_W'(255)) begin
      return 8'hFF;
    end else begin
      return v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bg_div_restoring.sv
// Restoring divider by a constant: one quotient bit per cycle, MSB first.
// The first bit is resolved on the Load edge so ACC_W bits take ACC_W edges.
module bg_div_restoring #(
  parameter int ACC_W   = 19,
  parameter int DIVISOR = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [ACC_W-1:0] dividend,
  output logic [ACC_W-1:0] quotient,
  output logic             Done
);

  localparam logic [ACC_W:0] DIV_C = (ACC_W+1)'(DIVISOR);
  localparam int             CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] r_rem;
  logic [ACC_W-1:0] r_dvd;
  logic [ACC_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [ACC_W-1:0] w_rem_src;
  logic             w_bit_src;
  logic [ACC_W:0]   w_trial;
  logic             w_ge;
  logic [ACC_W-1:0] w_rem_next;

  // Trial subtraction for the current bit, sourced from the dividend on Load
  always_comb begin
    w_rem_src = r_rem;
    w_bit_src = r_dvd[ACC_W-1];
    if (Load) begin
      w_rem_src = {ACC_W{1'b0}};
      w_bit_src = dividend[ACC_W-1];
    end else begin
      w_rem_src = r_rem;
      w_bit_src = r_dvd[ACC_W-1];
    end
    w_trial = {w_rem_src, w_bit_src};
    w_ge    = (w_trial >= DIV_C);
    if (w_ge) begin
      w_rem_next = ACC_W'(w_trial - DIV_C);
    end else begin
      w_rem_next = ACC_W'(w_trial);
    end
  end

  // Iteration registers; Done pulses once the last quotient bit is in place
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rem  <= {ACC_W{1'b0}};
      r_dvd  <= {ACC_W{1'b0}};
      r_quo  <= {ACC_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_done <= 1'b0;
    end else if (Load) begin
      r_rem  <= w_rem_next;
      r_dvd  <= dividend << 1;
      r_quo  <= {{(ACC_W-1){1'b0}}, w_ge};
      r_cnt  <= CNT_W'(ACC_W - 1);
      r_done <= (ACC_W == 1);
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_rem  <= w_rem_next;
      r_dvd  <= r_dvd << 1;
      r_quo  <= {r_quo[ACC_W-2:0], w_ge};
      r_cnt  <= r_cnt - CNT_W'(1);
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign quotient = r_quo;
  assign Done     = r_done;

endmodule

// File: rtl/bg_mean_calc.sv
// Collects per-PE channel sums after the summing pass, divides by the pixel
// count and presents the saturated 8-bit means as the array's expected colour.
module bg_mean_calc
  import bg_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int PIX_PER_PE = 4,
  parameter int SUM_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [NUM_PE-1:0]       Sum_Done,
  input  logic [NUM_PE*SUM_W-1:0] red_sum_all,
  input  logic [NUM_PE*SUM_W-1:0] green_sum_all,
  input  logic [NUM_PE*SUM_W-1:0] blue_sum_all,
  output logic                    Ack,
  output logic [PIX_W-1:0]        red_exp,
  output logic [PIX_W-1:0]        green_exp,
  output logic [PIX_W-1:0]        blue_exp,
  output logic                    Exp_Valid,
  output logic                    Busy
);

  localparam int ACC_W   = SUM_W + $clog2(NUM_PE) + 1;
  localparam int IDX_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int DIVISOR = NUM_PE * PIX_PER_PE;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_red_acc, r_grn_acc, r_blu_acc;
  logic             r_ack, r_exp_valid, r_busy;
  logic [PIX_W-1:0] r_red_exp, r_grn_exp, r_blu_exp;

  logic [SUM_W-1:0] w_red_pe, w_grn_pe, w_blu_pe;
  logic [ACC_W-1:0] w_red_sum, w_grn_sum, w_blu_sum;
  logic [ACC_W-1:0] w_red_quo, w_grn_quo, w_blu_quo;
  logic             w_red_done, w_grn_done, w_blu_done;
  logic             w_last, w_load, w_div_done;

  assign w_red_pe  = red_sum_all[r_idx*SUM_W +: SUM_W];
  assign w_grn_pe  = green_sum_all[r_idx*SUM_W +: SUM_W];
  assign w_blu_pe  = blue_sum_all[r_idx*SUM_W +: SUM_W];
  assign w_red_sum = r_red_acc + {{(ACC_W-SUM_W){1'b0}}, w_red_pe};
  assign w_grn_sum = r_grn_acc + {{(ACC_W-SUM_W){1'b0}}, w_grn_pe};
  assign w_blu_sum = r_blu_acc + {{(ACC_W-SUM_W){1'b0}}, w_blu_pe};

  assign w_last     = (r_idx == IDX_W'(NUM_PE - 1));
  // The dividers load the final sum directly so DIV can start on the Ack edge
  assign w_load     = (r_state == ST_ACC) && w_last;
  assign w_div_done = w_red_done & w_grn_done & w_blu_done;

  bg_div_restoring #(.ACC_W(ACC_W), .DIVISOR(DIVISOR)) u_div_red (
    .Clk(Clk), .Reset(Reset), .Load(w_load), .dividend(w_red_sum),
    .quotient(w_red_quo), .Done(w_red_done)
  );
  bg_div_restoring #(.ACC_W(ACC_W), .DIVISOR(DIVISOR)) u_div_grn (
    .Clk(Clk), .Reset(Reset), .Load(w_load), .dividend(w_grn_sum),
    .quotient(w_grn_quo), .Done(w_grn_done)
  );
  bg_div_restoring #(.ACC_W(ACC_W), .DIVISOR(DIVISOR)) u_div_blu (
    .Clk(Clk), .Reset(Reset), .Load(w_load), .dividend(w_blu_sum),
    .quotient(w_blu_quo), .Done(w_blu_done)
  );

  // Control FSM with registered Ack/Busy/Exp_Valid and result registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_red_acc   <= {ACC_W{1'b0}};
      r_grn_acc   <= {ACC_W{1'b0}};
      r_blu_acc   <= {ACC_W{1'b0}};
      r_ack       <= 1'b0;
      r_exp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_red_exp   <= {PIX_W{1'b0}};
      r_grn_exp   <= {PIX_W{1'b0}};
      r_blu_exp   <= {PIX_W{1'b0}};
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state     <= ST_WAIT;
            r_busy      <= 1'b1;
            r_exp_valid <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
            r_red_acc   <= {ACC_W{1'b0}};
            r_grn_acc   <= {ACC_W{1'b0}};
            r_blu_acc   <= {ACC_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (&Sum_Done) begin
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          r_red_acc <= w_red_sum;
          r_grn_acc <= w_grn_sum;
          r_blu_acc <= w_blu_sum;
          if (w_last) begin
            r_state <= ST_DIV;
            r_ack   <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_red_exp   <= sat8(SAT_IN_W'(w_red_quo));
            r_grn_exp   <= sat8(SAT_IN_W'(w_grn_quo));
            r_blu_exp   <= sat8(SAT_IN_W'(w_blu_quo));
            r_state     <= ST_DONE;
            r_exp_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_exp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Ack       = r_ack;
  assign Exp_Valid = r_exp_valid;
  assign Busy      = r_busy;
  assign red_exp   = r_red_exp;
  assign green_exp = r_grn_exp;
  assign blue_exp  = r_blu_exp;

endmodule

// File: tb/tb_bg_mean_calc.sv
// Randomized self-checking bench for bg_mean_calc against a plain-arithmetic
// mean model (total / pixel count, floored, saturated at 255).
module tb_bg_mean_calc;

  localparam int NUM_PE     = 4;
  localparam int PIX_PER_PE = 4;
  localparam int SUM_W      = 16;
  localparam int ACC_W      = SUM_W + $clog2(NUM_PE) + 1;
  localparam int NPIX       = NUM_PE * PIX_PER_PE;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    Start = 1'b0;
  logic [NUM_PE-1:0]       Sum_Done = '1;
  logic [NUM_PE*SUM_W-1:0] red_bus = '0, grn_bus = '0, blu_bus = '0;
  logic                    Ack, Exp_Valid, Busy;
  logic [7:0]              red_exp, green_exp, blue_exp;

  int n_tests = 0;
  int n_fail  = 0;
  int red_s[NUM_PE], grn_s[NUM_PE], blu_s[NUM_PE];
  int last_r = 0, last_g = 0, last_b = 0;
  bit have_result = 1'b0;

  bg_mean_calc #(.NUM_PE(NUM_PE), .PIX_PER_PE(PIX_PER_PE), .SUM_W(SUM_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Sum_Done(Sum_Done),
    .red_sum_all(red_bus), .green_sum_all(grn_bus), .blue_sum_all(blu_bus),
    .Ack(Ack), .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Exp_Valid(Exp_Valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int mean8(input int total);
    int q;
    q = total / NPIX;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic pack_sums();
    for (int i = 0; i < NUM_PE; i++) begin
      red_bus[i*SUM_W +: SUM_W] = SUM_W'(red_s[i]);
      grn_bus[i*SUM_W +: SUM_W] = SUM_W'(grn_s[i]);
      blu_bus[i*SUM_W +: SUM_W] = SUM_W'(blu_s[i]);
    end
  endtask

  task automatic run_job(input int w, input bit inj_start);
    int tr, tg, tb, cycles, acks, ack_cyc, lat, er, eg, eb;
    tr = 0; tg = 0; tb = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      tr += red_s[i]; tg += grn_s[i]; tb += blu_s[i];
    end
    er = mean8(tr); eg = mean8(tg); eb = mean8(tb);
    pack_sums();
    Sum_Done = '1;
    if (w > 0) Sum_Done[NUM_PE-1] = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("valid_drop", 32'(Exp_Valid), 32'd0);
    check("busy_start", 32'(Busy), 32'd1);
    if (have_result) begin
      check("hold_red", 32'(red_exp), last_r);
      check("hold_blue", 32'(blue_exp), last_b);
    end
    cycles = 0; acks = 0; ack_cyc = -1;
    lat = 1 + NUM_PE + ACC_W + w;
    while (!Exp_Valid && cycles < lat + 20) begin
      if (cycles == w) Sum_Done = '1;
      if (cycles < w) begin
        check("wait_busy", 32'(Busy), 32'd1);
        check("wait_ack", 32'(Ack), 32'd0);
      end
      Start = (inj_start && cycles == w + 2);
      tick();
      cycles++;
      if (Ack) begin
        acks++;
        ack_cyc = cycles;
        for (int i = 0; i < NUM_PE; i++) begin
          red_bus[i*SUM_W +: SUM_W] = SUM_W'($urandom);
          grn_bus[i*SUM_W +: SUM_W] = SUM_W'($urandom);
          blu_bus[i*SUM_W +: SUM_W] = SUM_W'($urandom);
        end
      end
    end
    Start = 1'b0;
    check("latency", cycles, lat);
    check("ack_count", acks, 32'd1);
    check("ack_cycle", ack_cyc, 1 + w + NUM_PE);
    check("red_exp", 32'(red_exp), er);
    check("green_exp", 32'(green_exp), eg);
    check("blue_exp", 32'(blue_exp), eb);
    check("busy_done", 32'(Busy), 32'd0);
    repeat (3) tick();
    check("valid_hold", 32'(Exp_Valid), 32'd1);
    check("red_hold", 32'(red_exp), er);
    check("green_hold", 32'(green_exp), eg);
    last_r = er; last_g = eg; last_b = eb;
    have_result = 1'b1;
  endtask

  initial begin
    int acks;
    bit full;
    repeat (2) tick();
    check("rst_valid", 32'(Exp_Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_red", 32'(red_exp), 32'd0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < NUM_PE; i++) begin red_s[i] = 160; grn_s[i] = 320; blu_s[i] = 0; end
    run_job(0, 1'b0);

    for (int i = 0; i < NUM_PE; i++) begin
      red_s[i] = $urandom_range(2047, 0); grn_s[i] = $urandom_range(2047, 0); blu_s[i] = $urandom_range(2047, 0);
    end
    run_job(10, 1'b0);

    red_s[0] = 15; red_s[1] = 15; red_s[2] = 15; red_s[3] = 16;
    for (int i = 0; i < NUM_PE; i++) begin grn_s[i] = $urandom_range(255, 0); blu_s[i] = 65535; end
    run_job(0, 1'b1);

    for (int i = 0; i < NUM_PE; i++) begin red_s[i] = 1200; grn_s[i] = 1020; blu_s[i] = 1023; end
    run_job(1, 1'b0);

    // Reset in the middle of DIV, then confirm the block stays quiet
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (1 + NUM_PE + 5) tick();
    check("div_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("abort_red", 32'(red_exp), 32'd0);
    check("abort_green", 32'(green_exp), 32'd0);
    check("abort_blue", 32'(blue_exp), 32'd0);
    check("abort_valid", 32'(Exp_Valid), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_ack", 32'(Ack), 32'd0);
    repeat (2) tick();
    Reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (Ack) acks++;
    end
    check("no_ack_after_rst", acks, 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
    have_result = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin red_s[i] = 100 + i; grn_s[i] = 4000; blu_s[i] = 7; end
    run_job(0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      full = j[0];
      for (int i = 0; i < NUM_PE; i++) begin
        red_s[i] = full ? $urandom_range(65535, 0) : $urandom_range(1500, 0);
        grn_s[i] = full ? $urandom_range(65535, 0) : $urandom_range(1500, 0);
        blu_s[i] = $urandom_range(1500, 0);
      end
      run_job($urandom_range(3, 0), j[1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_mean_calc.md
Name: bg_mean_calc

Overview:
- Downstream collector for the summing pass of the processing-element array. Waits until every PE reports sum-done, then accumulates the per-PE red/green/blue sums.
- Divides each channel total by the total pixel count. The results drive the array's red_exp/green_exp/blue_exp inputs.
- Issues Ack to the PEs so they return to idle before the background-removal pass starts.

Parameters:
- NUM_PE, 4, number of processing elements feeding this block (≥1)
- PIX_PER_PE, 4, pixels summed by each PE (≥1)
- SUM_W, 16, width of one PE's per-channel sum word
- ACC_W, SUM_W+$clog2(NUM_PE)+1, accumulator and dividend width (derived, not overridden)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse: begin collecting a new set of sums
- Sum_Done  in  NUM_PE  per-PE Qsd flags, bit i = PE i
- red_sum_all  in  NUM_PE*SUM_W  packed per-PE red sums, PE i at [i*SUM_W +: SUM_W]
- green_sum_all  in  NUM_PE*SUM_W  packed green sums, same packing
- blue_sum_all  in  NUM_PE*SUM_W  packed blue sums, same packing
- Ack  out  1  one-cycle pulse releasing all PEs from SUM_DONE
- red_exp  out  8  mean red value
- green_exp  out  8  mean green value
- blue_exp  out  8  mean blue value
- Exp_Valid  out  1  high while the exp outputs hold a completed result
- Busy  out  1  high in WAIT, ACC, DIV

Behaviour:
- Reset, asynchronous:
  - state IDLE
  - Ack=0, Exp_Valid=0, Busy=0
  - red_exp/green_exp/blue_exp=0
  - accumulators, index, divider cleared
- One-hot states: IDLE, WAIT, ACC, DIV, DONE.
- IDLE:
  - Start=1 → WAIT.
  - Clear the accumulators and set the PE index to 0.
  - Exp_Valid drops to 0 on the same edge.
- WAIT:
  - When Sum_Done is all-ones (&Sum_Done), go to ACC.
  - Otherwise stay in WAIT indefinitely; there is no timeout.
- ACC:
  - Each cycle, add PE[index] red/green/blue sums, zero-extended to ACC_W, into three accumulators. Increment index.
  - When index==NUM_PE-1: perform that add, then go to DIV and pulse Ack for exactly one cycle. Ack is registered and high during the first DIV cycle.
  - ACC lasts exactly NUM_PE cycles.
  - Sum inputs must stay stable from WAIT exit to ACC exit; the PEs guarantee this by holding in SUM_DONE until Ack.
- DIV:
  - Three parallel restoring dividers. Dividend = accumulator; divisor = NUM_PE*PIX_PER_PE, an elaboration-time constant and never zero.
  - One quotient bit per cycle, MSB first. DIV lasts exactly ACC_W cycles, then the block goes to DONE.
  - Quotient is truncated (floor); the remainder is discarded.
  - Each quotient saturates to 8'hFF if it exceeds 255.
  - The exp outputs are registered on DIV exit.
- DONE:
  - Exp_Valid=1 and the exp outputs hold their values.
  - Start=1 → WAIT with the same behaviour as from IDLE: Exp_Valid drops and the exp outputs keep their old values until the new DIV completes.
- Total latency, all done present at Start: 1 (WAIT) + NUM_PE (ACC) + ACC_W (DIV) cycles from the Start edge to Exp_Valid rising.
- Start while Busy is ignored. No restart.
- Sum_Done deasserting during WAIT simply keeps the block waiting. During ACC or DIV it is ignored.
- Reset mid-operation aborts immediately to the reset values. No Ack is emitted.
- Busy = state ∈ {WAIT, ACC, DIV}.

Decomposition:
- Shared package bg_pkg:
  - state encodings for IDLE/WAIT/ACC/DIV/DONE
  - the 8-bit pixel channel width constant
  - a saturate-to-8-bit function
- Sub-module bg_div_restoring:
  - parameters ACC_W and DIVISOR
  - ports Clk, Reset, Load, dividend, quotient, Done
  - instantiated three times, one per channel

Test Plan:
- NUM_PE=4, PIX_PER_PE=4. Red sums 160 each, green 320 each, blue 0. Start, with all Sum_Done already high → exactly 4+ACC_W+1 cycles later Exp_Valid=1, red_exp=40, green_exp=80, blue_exp=0. One Ack pulse.
- Sum_Done = 4'b0111 for 10 cycles, then 4'b1111 → stays in WAIT (Busy=1, no Ack) for the 10 cycles, then proceeds normally.
- Red sums {15,15,15,16} (total 61, /16 = 3.81) → red_exp=3 (truncation).
- Force out-of-range sums, red total 16*300 → red_exp=255 (saturation).
- Assert Reset during DIV → all outputs 0 on the same edge, no Ack afterward. A fresh Start then completes correctly.
- Pulse Start during ACC → ignored, result unchanged. Start again in DONE → Exp_Valid falls next cycle and the new result appears after the full latency.
